// File: rtl/mem_pkg.sv
// Shared constants, state encoding and access-legality check for the memory stage.
package mem_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned BE_W     = XLEN / 8;

  localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RETIRE = 2'd2
  } state_e;

  // High when the requested access is illegal or misaligned.
  function automatic logic access_fault(input logic          rd_en,
                                        input logic          wr_en,
                                        input logic [FUNCT3_W-1:0] f3,
                                        input logic [1:0]    lo);
    logic f;
    f = 1'b0;
    if (rd_en && wr_en) begin
      f = 1'b1;
    end else if (rd_en) begin
      f = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end else if (wr_en) begin
      f = !(f3 inside {F3_B, F3_H, F3_W});
    end
    if ((rd_en || wr_en) && (f3 == F3_H || f3 == F3_HU) && lo[0]) f = 1'b1;
    if ((rd_en || wr_en) && (f3 == F3_W) && (lo != 2'b00)) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a read word and sign/zero extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0]     rdata,
  input  logic [1:0]          addr,
  input  logic [FUNCT3_W-1:0] funct3,
  output logic [XLEN-1:0]     data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr, 3'b000} +: 8];
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'h000000, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'h0000, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: captures execute results, runs one data-memory
// req/ack access per load/store and emits a single registered writeback record.
module mem_stage
  import mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [XLEN-1:0]     ALU_result,
  input  logic [XLEN-1:0]     ReadData2,
  input  logic [REG_W-1:0]    rd,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic                RegWrite,
  output logic                stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [XLEN-1:0]     dmem_addr,
  output logic [XLEN-1:0]     dmem_wdata,
  output logic [BE_W-1:0]     dmem_be,
  input  logic                dmem_ack,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                wb_valid,
  output logic                wb_we,
  output logic [REG_W-1:0]    wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                mem_fault
);

  state_e                state_q, state_d;
  logic                  stall_q, stall_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [XLEN-1:0]       addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [1:0]            lo_q, lo_d;
  logic [FUNCT3_W-1:0]   f3_q, f3_d;
  logic [REG_W-1:0]      rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_we_q, wb_we_d;
  logic [REG_W-1:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  fault_q, fault_d;
  logic [XLEN-1:0]       load_data;

  mem_load_align u_align (
    .rdata  (dmem_rdata),
    .addr   (lo_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    lo_d       = lo_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = '0;
    wb_data_d  = '0;
    fault_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (access_fault(MemRead, MemWrite, funct3, ALU_result[1:0])) begin
            state_d    = RETIRE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd;
            fault_d    = 1'b1;
          end else if (MemRead || MemWrite) begin
            state_d = ACCESS;
            req_d   = 1'b1;
            we_d    = MemWrite;
            addr_d  = {ALU_result[XLEN-1:2], 2'b00};
            lo_d    = ALU_result[1:0];
            f3_d    = funct3;
            rd_d    = rd;
            rw_d    = RegWrite && MemRead && (rd != '0);
            // Loads read the whole word; alignment happens on the returned data.
            if (MemWrite) begin
              case (funct3)
                F3_B: begin
                  wdata_d = {4{ReadData2[7:0]}};
                  be_d    = 4'b0001 << ALU_result[1:0];
                end
                F3_H: begin
                  wdata_d = {2{ReadData2[15:0]}};
                  be_d    = ALU_result[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                  wdata_d = ReadData2;
                  be_d    = 4'b1111;
                end
              endcase
            end else begin
              wdata_d = '0;
              be_d    = 4'b1111;
            end
          end else begin
            state_d    = RETIRE;
            wb_valid_d = 1'b1;
            wb_we_d    = RegWrite && (rd != '0);
            wb_rd_d    = rd;
            wb_data_d  = ALU_result;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d    = RETIRE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          addr_d     = '0;
          wdata_d    = '0;
          be_d       = '0;
          wb_valid_d = 1'b1;
          wb_we_d    = rw_q;
          wb_rd_d    = rd_q;
          wb_data_d  = we_q ? '0 : load_data;
        end
      end
      RETIRE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      stall_q    <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      lo_q       <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      lo_q       <= lo_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      fault_q    <= fault_d;
    end
  end

  assign stall      = stall_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign mem_fault  = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected writeback records are queued at issue
// and checked against every wb_valid pulse.
module tb_mem_stage;

  logic        clk, rst_n, in_valid;
  logic [31:0] ALU_result, ReadData2;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        MemRead, MemWrite, RegWrite;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_fault;

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic [4:0]  rd;
    logic        fault;
    logic        chk_data;
  } wb_exp_t;

  wb_exp_t sb[$];
  int total = 0;
  int bad = 0;
  int retired = 0;
  int pushed = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .ALU_result(ALU_result), .ReadData2(ReadData2), .rd(rd), .funct3(funct3),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_fault(mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic we, input logic [4:0] r,
                          input logic f, input logic cd);
    wb_exp_t e;
    e.data = d; e.we = we; e.rd = r; e.fault = f; e.chk_data = cd;
    sb.push_back(e);
    pushed++;
  endtask

  // Presents one instruction once stall is low; returns in the cycle after acceptance.
  task automatic issue(input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] r,
                       input logic [2:0] f3, input logic mr, input logic mw, input logic rw);
    int n;
    n = 0;
    while (stall !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("issue_wait_timeout", 32'(stall), 32'h0);
    ALU_result = alu; ReadData2 = rd2; rd = r; funct3 = f3;
    MemRead = mr; MemWrite = mw; RegWrite = rw;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ALU_result = 32'hDEAD_BEEF; ReadData2 = 32'hDEAD_BEEF;
  endtask

  // Serves a memory access with ack in the k-th request cycle.
  task automatic serve(input string tag, input int k, input logic [31:0] rdata,
                       input logic [31:0] eaddr, input logic [3:0] ebe, input logic ewe,
                       input logic [31:0] ewdata, input logic chk_wd);
    for (int i = 1; i <= k; i++) begin
      chk({tag, "_req"}, 32'(dmem_req), 32'h1);
      chk({tag, "_stall"}, 32'(stall), 32'h1);
      chk({tag, "_wbv_busy"}, 32'(wb_valid), 32'h0);
      chk({tag, "_addr"}, dmem_addr, eaddr);
      chk({tag, "_be"}, 32'(dmem_be), 32'(ebe));
      chk({tag, "_we"}, 32'(dmem_we), 32'(ewe));
      if (chk_wd) chk({tag, "_wdata"}, dmem_wdata, ewdata);
      if (i == k) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
      end
      tick();
      dmem_ack = 1'b0;
      dmem_rdata = 32'h0;
    end
    chk({tag, "_wbv"}, 32'(wb_valid), 32'h1);
    chk({tag, "_req_drop"}, 32'(dmem_req), 32'h0);
    chk({tag, "_stall_ret"}, 32'(stall), 32'h1);
    tick();
    chk({tag, "_wbv_end"}, 32'(wb_valid), 32'h0);
    chk({tag, "_stall_end"}, 32'(stall), 32'h0);
  endtask

  task automatic fast_retire(input string tag, input logic f);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'h1);
    chk({tag, "_fault"}, 32'(mem_fault), 32'(f));
    chk({tag, "_stall"}, 32'(stall), 32'h1);
    chk({tag, "_noreq"}, 32'(dmem_req), 32'h0);
    tick();
    chk({tag, "_wbv_end"}, 32'(wb_valid), 32'h0);
    chk({tag, "_fault_end"}, 32'(mem_fault), 32'h0);
    chk({tag, "_stall_end"}, 32'(stall), 32'h0);
  endtask

  // Scoreboard: every retire pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      wb_exp_t e;
      retired++;
      chk("sb_nonempty", 32'(sb.size() > 0), 32'h1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_we", 32'(wb_we), 32'(e.we));
        chk("sb_rd", 32'(wb_rd), 32'(e.rd));
        chk("sb_fault", 32'(mem_fault), 32'(e.fault));
        if (e.chk_data) chk("sb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    int r0;
    rst_n = 1'b0; in_valid = 1'b0; ALU_result = '0; ReadData2 = '0; rd = '0;
    funct3 = '0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    tick(); tick();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_wbv", 32'(wb_valid), 32'h0);
    chk("rst_wbdata", wb_data, 32'h0);
    chk("rst_be", 32'(dmem_be), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // ALU op
    push_exp(32'h0000_1234, 1'b1, 5'd5, 1'b0, 1'b1);
    issue(32'h0000_1234, 32'h0, 5'd5, 3'b000, 1'b0, 1'b0, 1'b1);
    fast_retire("alu", 1'b0);

    // Loads
    push_exp(32'hFFFF_FF80, 1'b1, 5'd6, 1'b0, 1'b1);
    issue(32'h0000_0103, 32'h0, 5'd6, 3'b000, 1'b1, 1'b0, 1'b1);
    serve("lb", 3, 32'h80FF_0000, 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 1'b0);

    push_exp(32'h0000_BEEF, 1'b1, 5'd7, 1'b0, 1'b1);
    issue(32'h0000_0102, 32'h0, 5'd7, 3'b101, 1'b1, 1'b0, 1'b1);
    serve("lhu", 1, 32'hBEEF_0000, 32'h0000_0100, 4'b1111, 1'b0, 32'h0, 1'b0);

    push_exp(32'h0000_007F, 1'b1, 5'd8, 1'b0, 1'b1);
    issue(32'h0000_0201, 32'h0, 5'd8, 3'b000, 1'b1, 1'b0, 1'b1);
    serve("lb_pos", 2, 32'h0000_7F00, 32'h0000_0200, 4'b1111, 1'b0, 32'h0, 1'b0);

    push_exp(32'hFFFF_8001, 1'b1, 5'd9, 1'b0, 1'b1);
    issue(32'h0000_0300, 32'h0, 5'd9, 3'b001, 1'b1, 1'b0, 1'b1);
    serve("lh", 1, 32'h1234_8001, 32'h0000_0300, 4'b1111, 1'b0, 32'h0, 1'b0);

    push_exp(32'h0000_00F0, 1'b1, 5'd10, 1'b0, 1'b1);
    issue(32'h0000_0402, 32'h0, 5'd10, 3'b100, 1'b1, 1'b0, 1'b1);
    serve("lbu", 1, 32'h00F0_0000, 32'h0000_0400, 4'b1111, 1'b0, 32'h0, 1'b0);

    push_exp(32'hCAFE_F00D, 1'b1, 5'd11, 1'b0, 1'b1);
    issue(32'h0000_0508, 32'h0, 5'd11, 3'b010, 1'b1, 1'b0, 1'b1);
    serve("lw", 2, 32'hCAFE_F00D, 32'h0000_0508, 4'b1111, 1'b0, 32'h0, 1'b0);

    // Stores
    push_exp(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    issue(32'h0000_0101, 32'h0000_00AB, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0);
    serve("sb", 2, 32'h0, 32'h0000_0100, 4'b0010, 1'b1, 32'hABAB_ABAB, 1'b1);

    push_exp(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    issue(32'h0000_0102, 32'h1234_5678, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0);
    serve("sh", 1, 32'h0, 32'h0000_0100, 4'b1100, 1'b1, 32'h5678_5678, 1'b1);

    push_exp(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    issue(32'h0000_0104, 32'h1234_5678, 5'd0, 3'b010, 1'b0, 1'b1, 1'b0);
    serve("sw", 1, 32'h0, 32'h0000_0104, 4'b1111, 1'b1, 32'h1234_5678, 1'b1);

    // Faults
    push_exp(32'h0, 1'b0, 5'd12, 1'b1, 1'b0);
    issue(32'h0000_0102, 32'h0, 5'd12, 3'b010, 1'b1, 1'b0, 1'b1);
    fast_retire("f_lw_mis", 1'b1);

    push_exp(32'h0, 1'b0, 5'd13, 1'b1, 1'b0);
    issue(32'h0000_0100, 32'h0, 5'd13, 3'b010, 1'b1, 1'b1, 1'b1);
    fast_retire("f_rdwr", 1'b1);

    push_exp(32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    issue(32'h0000_0103, 32'h0, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0);
    fast_retire("f_sh_mis", 1'b1);

    push_exp(32'h0, 1'b0, 5'd14, 1'b1, 1'b0);
    issue(32'h0000_0100, 32'h0, 5'd14, 3'b011, 1'b1, 1'b0, 1'b1);
    fast_retire("f_ld_f3", 1'b1);

    push_exp(32'h0, 1'b0, 5'd0, 1'b1, 1'b0);
    issue(32'h0000_0100, 32'h0, 5'd0, 3'b100, 1'b0, 1'b1, 1'b0);
    fast_retire("f_st_f3", 1'b1);

    // rd=0 suppresses the register write
    push_exp(32'h0000_5555, 1'b0, 5'd0, 1'b0, 1'b1);
    issue(32'h0000_5555, 32'h0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    fast_retire("alu_x0", 1'b0);

    // Reset in the middle of an access; the late ack must be ignored
    r0 = retired;
    issue(32'h0000_0600, 32'h0, 5'd15, 3'b010, 1'b1, 1'b0, 1'b1);
    chk("ra_req", 32'(dmem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_req_rst", 32'(dmem_req), 32'h0);
    chk("ra_stall_rst", 32'(stall), 32'h0);
    chk("ra_wbv_rst", 32'(wb_valid), 32'h0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1111_1111;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("ra_late_req", 32'(dmem_req), 32'h0);
    chk("ra_late_wbv", 32'(wb_valid), 32'h0);
    tick();
    chk("ra_late_stall", 32'(stall), 32'h0);
    chk("ra_late_wbv2", 32'(wb_valid), 32'h0);
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    chk("ra_no_retire", 32'(retired - r0), 32'h0);
    push_exp(32'h0000_0777, 1'b1, 5'd16, 1'b0, 1'b1);
    issue(32'h0000_0777, 32'h0, 5'd16, 3'b000, 1'b0, 1'b0, 1'b1);
    fast_retire("ra_alu", 1'b0);

    // Back-to-back: second op held by the driver while stall is high
    r0 = retired;
    push_exp(32'h0000_0011, 1'b1, 5'd3, 1'b0, 1'b1);
    issue(32'h0000_0011, 32'h0, 5'd3, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("b2b_stall", 32'(stall), 32'h1);
    push_exp(32'h0000_0022, 1'b1, 5'd4, 1'b0, 1'b1);
    ALU_result = 32'h0000_0022; rd = 5'd4; funct3 = 3'b000;
    MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b1;
    in_valid = 1'b1;
    tick();
    chk("b2b_idle", 32'(stall), 32'h0);
    chk("b2b_not_taken", 32'(wb_valid), 32'h0);
    tick();
    in_valid = 1'b0;
    chk("b2b_wbv", 32'(wb_valid), 32'h1);
    chk("b2b_data", wb_data, 32'h0000_0022);
    tick();
    chk("b2b_wbv_end", 32'(wb_valid), 32'h0);
    tick();
    chk("b2b_retired", 32'(retired - r0), 32'h2);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("retire_count", 32'(retired), 32'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
